// File: rtl/burst_sample_fifo.sv
// burst_sample_fifo: single-clock sample FIFO with show-ahead readout.
// Samples are buffered while collection is enabled; dataReadyFlag is raised
// once a full burst is stored and held until exactly that burst has been read.
// Overflowing writes are dropped and counted; collectEnable low flushes everything.
module burst_sample_fifo #(
   parameter int DATA_WIDTH   = 10,
   parameter int ADDR_WIDTH   = 15,
   parameter int BURST_LEN    = 8192,
   parameter int STICKY_ERROR = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  collectEnable,
   input  logic                  inputValid,
   input  logic [DATA_WIDTH-1:0] inputData,
   input  logic                  outputAck,
   output logic [DATA_WIDTH-1:0] outputData,
   output logic                  outputValid,
   output logic                  dataReadyFlag,
   output logic                  errorFlag,
   output logic [ADDR_WIDTH:0]   level,
   output logic [15:0]           overflowCount
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int BCW   = $clog2(BURST_LEN + 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_LVL     = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] BURST_LVL     = (ADDR_WIDTH+1)'(BURST_LEN);
   localparam logic [BCW-1:0]      BURST_CNT_END = BCW'(BURST_LEN);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILLING = 2'd1,
      BURST   = 2'd2
   } state_t;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   level_q, level_d;
   logic [15:0]           ovf_cnt_q, ovf_cnt_d;
   logic                  err_q, err_d;
   state_t                state_q;
   logic [BCW-1:0]        burst_cnt_q;
   logic                  ready_q;

   logic not_empty;
   logic rd_acc;
   logic wr_acc;
   logic overflow;

   // Handshake decode; a read frees a slot, so a full FIFO still accepts a write alongside it
   always_comb begin
      not_empty = (level_q != '0);
      rd_acc    = collectEnable & outputAck & not_empty;
      wr_acc    = collectEnable & inputValid & ((level_q < DEPTH_LVL) | rd_acc);
      overflow  = collectEnable & inputValid & (level_q == DEPTH_LVL) & ~rd_acc;
   end

   // Next-state for pointers, level, drop counter and error flag (flush wins)
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      ovf_cnt_d = ovf_cnt_q;
      err_d     = (STICKY_ERROR != 0) ? err_q : 1'b0;
      if (!collectEnable) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         level_d   = '0;
         ovf_cnt_d = '0;
         err_d     = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
         if (wr_acc && !rd_acc) level_d = level_q + 1'b1;
         else if (rd_acc && !wr_acc) level_d = level_q - 1'b1;
         if (overflow) begin
            err_d = 1'b1;
            if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
         end
      end
   end

   // Datapath state registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         ovf_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         ovf_cnt_q <= ovf_cnt_d;
         err_q     <= err_d;
      end
   end

   // Sample storage; contents need no reset because level gates visibility
   always_ff @(posedge clock) begin
      if (wr_acc) mem_q[wr_ptr_q] <= inputData;
   end

   // Burst grant FSM: FILLING waits for a full burst, BURST counts exactly BURST_LEN reads
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         burst_cnt_q <= '0;
         ready_q     <= 1'b0;
      end else if (!collectEnable) begin
         state_q     <= IDLE;
         burst_cnt_q <= '0;
         ready_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= FILLING;
               ready_q <= 1'b0;
            end
            FILLING: begin
               if (level_q >= BURST_LVL) begin
                  state_q     <= BURST;
                  burst_cnt_q <= '0;
                  ready_q     <= 1'b1;
               end
            end
            BURST: begin
               if (rd_acc) begin
                  if (burst_cnt_q + 1'b1 == BURST_CNT_END) begin
                     state_q     <= FILLING;
                     burst_cnt_q <= '0;
                     ready_q     <= 1'b0;
                  end else begin
                     burst_cnt_q <= burst_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               burst_cnt_q <= '0;
               ready_q     <= 1'b0;
            end
         endcase
      end
   end

   assign outputValid   = not_empty;
   assign outputData    = not_empty ? mem_q[rd_ptr_q] : '0;
   assign dataReadyFlag = ready_q;
   assign errorFlag     = err_q;
   assign level         = level_q;
   assign overflowCount = ovf_cnt_q;

endmodule

// File: tb/tb_burst_sample_fifo.sv
// Directed bench for burst_sample_fifo (ADDR_WIDTH=4, BURST_LEN=8, DATA_WIDTH=10).
module tb_burst_sample_fifo;

   localparam int DW = 10;
   localparam int AW = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          collectEnable;
   logic          inputValid;
   logic [DW-1:0] inputData;
   logic          outputAck;
   logic [DW-1:0] outputData;
   logic          outputValid;
   logic          dataReadyFlag;
   logic          errorFlag;
   logic [AW:0]   level;
   logic [15:0]   overflowCount;

   int vectors     = 0;
   int miscompares = 0;

   burst_sample_fifo #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .BURST_LEN   (8),
      .STICKY_ERROR(1)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .collectEnable(collectEnable),
      .inputValid   (inputValid),
      .inputData    (inputData),
      .outputAck    (outputAck),
      .outputData   (outputData),
      .outputValid  (outputValid),
      .dataReadyFlag(dataReadyFlag),
      .errorFlag    (errorFlag),
      .level        (level),
      .overflowCount(overflowCount)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
      $display("vec %0d %s: observed %0d expected %0d", vectors, tag, obs, exp);
   endtask

   initial begin
      reset = 1'b1; collectEnable = 1'b0; inputValid = 1'b0;
      inputData = '0; outputAck = 1'b0;
      #2;
      chk("rst_level", 32'(level), 0);
      chk("rst_valid", 32'(outputValid), 0);
      chk("rst_ready", 32'(dataReadyFlag), 0);
      chk("rst_err", 32'(errorFlag), 0);
      chk("rst_ovf", 32'(overflowCount), 0);
      chk("rst_data", 32'(outputData), 0);
      tick();
      reset = 1'b0;
      tick();

      // enable: IDLE -> FILLING
      collectEnable = 1'b1;
      tick();
      // write 0..7
      for (int i = 0; i < 8; i++) begin
         inputValid = 1'b1; inputData = DW'(i);
         tick();
      end
      inputValid = 1'b0;
      chk("fill_level", 32'(level), 8);
      chk("fill_ready_not_yet", 32'(dataReadyFlag), 0);
      chk("fill_valid", 32'(outputValid), 1);
      chk("fill_head", 32'(outputData), 0);
      tick();
      chk("burst_ready", 32'(dataReadyFlag), 1);

      // read the burst
      for (int i = 0; i < 8; i++) begin
         chk("burst_data", 32'(outputData), 32'(i));
         outputAck = 1'b1;
         tick();
         if (i < 7) chk("burst_ready_hold", 32'(dataReadyFlag), 1);
      end
      outputAck = 1'b0;
      chk("burst_end_ready", 32'(dataReadyFlag), 0);
      chk("burst_end_level", 32'(level), 0);
      chk("burst_end_valid", 32'(outputValid), 0);
      chk("burst_end_data", 32'(outputData), 0);

      // ack while empty
      outputAck = 1'b1;
      tick();
      outputAck = 1'b0;
      chk("empty_ack_level", 32'(level), 0);
      chk("empty_ack_valid", 32'(outputValid), 0);

      // 18 writes, no reads: 16 stored (pointer wrap), 2 dropped
      for (int i = 0; i < 18; i++) begin
         inputValid = 1'b1; inputData = DW'(100 + i);
         tick();
      end
      inputValid = 1'b0;
      chk("ovf_level", 32'(level), 16);
      chk("ovf_count", 32'(overflowCount), 2);
      chk("ovf_err", 32'(errorFlag), 1);
      tick();
      tick();
      chk("ovf_err_sticky", 32'(errorFlag), 1);
      chk("ovf_ready", 32'(dataReadyFlag), 1);
      chk("ovf_head", 32'(outputData), 100);

      // simultaneous write + read while full
      inputValid = 1'b1; inputData = DW'(200); outputAck = 1'b1;
      tick();
      inputValid = 1'b0; outputAck = 1'b0;
      chk("full_rw_level", 32'(level), 16);
      chk("full_rw_ovf", 32'(overflowCount), 2);
      chk("full_rw_head", 32'(outputData), 101);

      // four more reads -> level 12, still inside the burst
      for (int i = 0; i < 4; i++) begin
         chk("mid_data", 32'(outputData), 32'(101 + i));
         outputAck = 1'b1;
         tick();
      end
      outputAck = 1'b0;
      chk("mid_level", 32'(level), 12);
      chk("mid_ready", 32'(dataReadyFlag), 1);

      // async reset mid-burst, checked before the next edge
      reset = 1'b1;
      #1;
      chk("arst_level", 32'(level), 0);
      chk("arst_ready", 32'(dataReadyFlag), 0);
      chk("arst_err", 32'(errorFlag), 0);
      chk("arst_ovf", 32'(overflowCount), 0);
      chk("arst_valid", 32'(outputValid), 0);
      chk("arst_data", 32'(outputData), 0);
      tick();
      reset = 1'b0;

      // refill: 17 writes, first edge also moves IDLE -> FILLING
      for (int i = 0; i < 17; i++) begin
         inputValid = 1'b1; inputData = DW'(300 + i);
         tick();
      end
      inputValid = 1'b0;
      chk("r2_level", 32'(level), 16);
      chk("r2_ovf", 32'(overflowCount), 1);
      chk("r2_ready", 32'(dataReadyFlag), 1);
      chk("r2_head", 32'(outputData), 300);
      outputAck = 1'b1;
      tick();
      outputAck = 1'b0;
      chk("r2_next", 32'(outputData), 301);

      // flush mid-burst; write and read requests in the flush cycle are discarded
      collectEnable = 1'b0; inputValid = 1'b1; inputData = DW'(55); outputAck = 1'b1;
      tick();
      inputValid = 1'b0; outputAck = 1'b0;
      chk("flush_level", 32'(level), 0);
      chk("flush_ready", 32'(dataReadyFlag), 0);
      chk("flush_err", 32'(errorFlag), 0);
      chk("flush_ovf", 32'(overflowCount), 0);
      chk("flush_valid", 32'(outputValid), 0);
      collectEnable = 1'b1;
      tick();
      chk("reen_level", 32'(level), 0);
      inputValid = 1'b1; inputData = DW'(7);
      tick();
      inputValid = 1'b0;
      chk("reen_level1", 32'(level), 1);
      chk("reen_head", 32'(outputData), 7);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
